// File: rtl/fsm_regress_pkg.sv
// Shared constants, control-state encoding and reference next-state helpers
// for the fsm_N stimulus/checker harness.
package fsm_regress_pkg;

  localparam int NUM_STATES = 9;
  localparam int STATE_W    = 4;
  localparam int LEN_W      = 16;
  localparam int ERR_W      = 8;

  // x^8+x^6+x^5+x^4+1, Fibonacci form: feedback taps are bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chk_state_t;

  function automatic logic [STATE_W-1:0] ref_next(input logic [STATE_W-1:0] s,
                                                  input logic [NUM_STATES-1:0] adv);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_STATES; k++) begin
      if (s == STATE_W'(k)) hit = adv[k];
    end
    if (!hit) return s;
    if (s == STATE_W'(NUM_STATES - 1)) return '0;
    return s + STATE_W'(1);
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/fsm_stim_checker_if.sv
// Bundle between the stimulus checker (master) and the harness / FSM under
// test (slave): control inputs, DUT state code, advance vector and results.
interface fsm_stim_checker_if;
  import fsm_regress_pkg::*;

  logic                  start;
  logic [NUM_STATES-1:0] adv_mask;
  logic [LEN_W-1:0]      run_len;
  logic [STATE_W-1:0]    y;
  logic [NUM_STATES-1:0] i;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [ERR_W-1:0]      err_count;
  logic [LEN_W-1:0]      first_err_cyc;

  modport master (
    input  start, adv_mask, run_len, y,
    output i, busy, done, pass, err_count, first_err_cyc
  );

  modport slave (
    output start, adv_mask, run_len, y,
    input  i, busy, done, pass, err_count, first_err_cyc
  );

endinterface

// File: rtl/fsm_ref_model.sv
// Expected-state register for the FSM under test; advances on the same edge
// as the DUT from the advance vector actually driven.
module fsm_ref_model
  import fsm_regress_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_STATES-1:0] i,
  output logic [STATE_W-1:0]    exp
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) exp <= '0;
    else       exp <= ref_next(exp, i);
  end

endmodule

// File: rtl/fsm_stim_checker.sv
// Drives the advance vector of an fsm_N instance and scores its state code.
// Define FSM_STIM_STALL_EN to add LFSR-driven stall cycles during RUN.
module fsm_stim_checker
  import fsm_regress_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  fsm_stim_checker_if.master bus
);

  chk_state_t            state_reg, state_next;
  logic [NUM_STATES-1:0] mask_reg;
  logic [NUM_STATES-1:0] i_reg, i_next;
  logic [LEN_W-1:0]      len_reg;
  logic [LEN_W-1:0]      cyc_reg;
  logic [LEN_W-1:0]      first_reg;
  logic [ERR_W-1:0]      err_reg;
  logic [STATE_W-1:0]    exp;
  logic                  accept;
  logic                  checking;
  logic                  mismatch;
  logic                  last_run;
  logic                  stall;

`ifdef FSM_STIM_STALL_EN
  logic [7:0] lfsr_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  lfsr_reg <= LFSR_SEED;
    else if (state_reg == RUN)  lfsr_reg <= lfsr_step(lfsr_reg);
  end

  assign stall = lfsr_reg[0];
`else
  assign stall = 1'b0;
`endif

  assign accept   = bus.start && (state_reg == IDLE || state_reg == DONE);
  assign checking = (state_reg == RUN) || (state_reg == DRAIN);
  assign last_run = (cyc_reg == len_reg - LEN_W'(1));
  assign mismatch = checking && ((bus.y != exp) || (bus.y >= STATE_W'(NUM_STATES)));

  // i is registered, so it is decided one cycle ahead of the state that shows it
  always_comb begin
    state_next = state_reg;
    i_next     = '0;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          if (bus.run_len == '0) begin
            state_next = DRAIN;
          end else begin
            state_next = RUN;
            i_next     = stall ? '0 : bus.adv_mask;
          end
        end
      end
      RUN: begin
        if (last_run) state_next = DRAIN;
        else          i_next     = stall ? '0 : mask_reg;
      end
      DRAIN:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      i_reg     <= '0;
      mask_reg  <= '0;
      len_reg   <= '0;
      cyc_reg   <= '0;
      err_reg   <= '0;
      first_reg <= '0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      if (accept) begin
        mask_reg  <= bus.adv_mask;
        len_reg   <= bus.run_len;
        cyc_reg   <= '0;
        err_reg   <= '0;
        first_reg <= '0;
      end else begin
        if (state_reg == RUN) cyc_reg <= cyc_reg + LEN_W'(1);
        if (mismatch) begin
          if (err_reg != '1) err_reg   <= err_reg + ERR_W'(1);
          if (err_reg == '0) first_reg <= cyc_reg;
        end
      end
    end
  end

  fsm_ref_model u_ref (
    .clock (clock),
    .reset (reset),
    .i     (i_reg),
    .exp   (exp)
  );

  assign bus.i             = i_reg;
  assign bus.busy          = checking;
  assign bus.done          = (state_reg == DONE);
  assign bus.pass          = (state_reg == DONE) && (err_reg == '0);
  assign bus.err_count     = err_reg;
  assign bus.first_err_cyc = first_reg;

endmodule
